// File: rtl/iter_alu.sv
// iter_alu: single-issue ALU with 1-cycle ops and an iterative shift-add MUL.
// Result and {N,Z,C,V} flags are registered behind a valid/ready handshake.
module iter_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] ScrA,
    input  logic [WIDTH-1:0] ScrB,
    input  logic [2:0]       ALUControl,
    input  logic             FlagEn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic             Busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] acc, acc_nx, mcand, mplier;
    logic [SW-1:0]    cnt;
    logic             fe;

    logic             accept, start_mul, mul_done;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum, diff, shl;
    logic             cf, vf, upd_flags;

    assign InReady   = (state == IDLE) && (!OutValid || OutReady);
    assign Busy      = (state == MUL);
    assign accept    = InValid && InReady;
    assign start_mul = accept && MUL_EN && (ALUControl == OP_MUL);
    assign mul_done  = (state == MUL) && (cnt == LAST);
    assign acc_nx    = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge CLK) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start_mul) state_nx = MUL;
            MUL:  if (mul_done)  state_nx = IDLE;
        endcase
    end

    // Single-cycle datapath; C and V default to their held values.
    always_comb begin
        res  = '0;
        cf   = ALUFlags[1];
        vf   = ALUFlags[0];
        sum  = {1'b0, ScrA} + {1'b0, ScrB};
        diff = {1'b0, ScrA} - {1'b0, ScrB};
        shl  = {1'b0, ScrA} << ScrB[SW-1:0];
        unique case (ALUControl)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                vf  = (ScrA[WIDTH-1] == ScrB[WIDTH-1]) &&
                      (res[WIDTH-1] != ScrA[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res = diff[WIDTH-1:0];
                cf  = ~diff[WIDTH];
                vf  = (ScrA[WIDTH-1] != ScrB[WIDTH-1]) &&
                      (res[WIDTH-1] != ScrA[WIDTH-1]);
            end
            OP_AND: res = ScrA & ScrB;
            OP_ORR: res = ScrA | ScrB;
            OP_MOV: res = ScrB;
            OP_LSL: begin
                res = shl[WIDTH-1:0];
                if (ScrB[SW-1:0] != '0) cf = shl[WIDTH];
            end
            OP_MUL: res = '0;
        endcase
    end

    assign upd_flags = (ALUControl == OP_CMP) ||
                       (FlagEn && ALUControl != OP_MUL);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            ALUResult <= '0;
            ALUFlags  <= '0;
            OutValid  <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            fe        <= 1'b0;
        end else begin
            if (start_mul) begin
                OutValid <= 1'b0;
                acc      <= '0;
                mcand    <= ScrA;
                mplier   <= ScrB;
                cnt      <= '0;
                fe       <= FlagEn;
            end else if (accept) begin
                if (ALUControl != OP_CMP) begin
                    ALUResult <= res;
                    OutValid  <= 1'b1;
                end else if (OutReady) begin
                    OutValid <= 1'b0;
                end
                if (upd_flags)
                    ALUFlags <= {res[WIDTH-1], res == '0, cf, vf};
            end else if (mul_done) begin
                ALUResult <= acc_nx;
                OutValid  <= 1'b1;
                if (fe)
                    ALUFlags[3:2] <= {acc_nx[WIDTH-1], acc_nx == '0};
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
            if (state == MUL) begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and random checks of iter_alu (WIDTH=32)
// against an arithmetic reference model.
module tb_iter_alu;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        InValid;
    logic        InReady;
    logic [31:0] ScrA, ScrB;
    logic [2:0]  ALUControl;
    logic        FlagEn;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;
    logic        Busy;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_res;
    logic [3:0]  m_flags;
    logic        m_valid;

    iter_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .InValid(InValid), .InReady(InReady),
        .ScrA(ScrA), .ScrB(ScrB),
        .ALUControl(ALUControl), .FlagEn(FlagEn),
        .OutValid(OutValid), .OutReady(OutReady),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: what one accepted op does to result/flags/valid.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fe);
        logic [63:0] w;
        logic [31:0] r;
        longint      sa, sb, sr, rs;
        logic        c, v;
        int          sh;
        sa = $signed(a);
        sb = $signed(b);
        sr = 0;
        r  = '0;
        c  = m_flags[1];
        v  = m_flags[0];
        case (op)
            3'd0: begin
                w  = 64'(a) + 64'(b);
                r  = w[31:0];
                c  = w > 64'hFFFF_FFFF;
                sr = sa + sb;
                rs = $signed(r);
                v  = sr != rs;
            end
            3'd1, 3'd7: begin
                r  = a - b;
                c  = a >= b;
                sr = sa - sb;
                rs = $signed(r);
                v  = sr != rs;
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = b;
            3'd5: begin
                sh = int'(b[4:0]);
                r  = a << sh;
                if (sh != 0) c = a[32 - sh];
            end
            default: begin
                w = 64'(a) * 64'(b);
                r = w[31:0];
            end
        endcase
        if (fe || op == 3'd7) begin
            if (op == 3'd6) m_flags[3:2] = {r[31], r == 0};
            else            m_flags = {r[31], r == 0, c, v};
        end
        if (op != 3'd7) begin
            m_res   = r;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_valid"}, OutValid, m_valid);
        chk({tag, "_res"}, ALUResult, m_res);
        chk({tag, "_flags"}, ALUFlags, m_flags);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fe);
        chk("in_ready", InReady, 1'b1);
        ScrA       = a;
        ScrB       = b;
        ALUControl = op;
        FlagEn     = fe;
        InValid    = 1'b1;
        tick();
        InValid = 1'b0;
        ScrA    = $urandom;
        ScrB    = $urandom;
        model(op, a, b, fe);
        if (op == 3'd6) begin
            for (int i = 0; i < 32; i++) begin
                chk("mul_busy", Busy, 1'b1);
                chk("mul_in_ready", InReady, 1'b0);
                chk("mul_valid_early", OutValid, 1'b0);
                tick();
            end
        end
        chk("busy_idle", Busy, 1'b0);
        check_out("op");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            m_valid = 1'b0;
        end
        chk("idle_valid", OutValid, m_valid);
    endtask

    initial begin
        logic stale;
        RESETn     = 1'b0;
        InValid    = 1'b0;
        ScrA       = '0;
        ScrB       = '0;
        ALUControl = '0;
        FlagEn     = 1'b0;
        OutReady   = 1'b1;
        m_res      = '0;
        m_flags    = '0;
        m_valid    = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        chk("rst_valid", OutValid, 1'b0);
        chk("rst_res", ALUResult, 32'h0);
        chk("rst_flags", ALUFlags, 4'h0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_in_ready", InReady, 1'b1);

        do_op(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("add_wrap_res", ALUResult, 32'h0);
        chk("add_wrap_flags", ALUFlags, 4'b0110);

        do_op(3'd1, 32'h8000_0000, 32'h1, 1'b1);
        chk("sub_ovf_res", ALUResult, 32'h7FFF_FFFF);
        chk("sub_ovf_flags", ALUFlags, 4'b0011);
        do_op(3'd7, 32'd5, 32'd5, 1'b0);
        chk("cmp_flags", ALUFlags, 4'b0110);
        chk("cmp_res_kept", ALUResult, 32'h7FFF_FFFF);

        idle(1);
        do_op(3'd6, 32'd7, 32'd6, 1'b1);
        chk("mul_res", ALUResult, 32'd42);

        do_op(3'd5, 32'h8000_0001, 32'd1, 1'b1);
        chk("lsl1_res", ALUResult, 32'h2);
        chk("lsl1_c", ALUFlags[1], 1'b1);
        do_op(3'd5, 32'h1234_5678, 32'd0, 1'b1);
        chk("lsl0_c", ALUFlags[1], 1'b1);

        // Backpressure: result must hold, new requests ignored.
        idle(2);
        OutReady = 1'b0;
        do_op(3'd0, 32'd100, 32'd23, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ScrA       = $urandom;
            ScrB       = $urandom;
            ALUControl = 3'd0;
            InValid    = 1'b1;
            tick();
            check_out("bp_hold");
            chk("bp_in_ready", InReady, 1'b0);
        end
        ScrA     = 32'd1000;
        ScrB     = 32'd234;
        FlagEn   = 1'b0;
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        model(3'd0, 32'd1000, 32'd234, 1'b0);
        check_out("bp_new");

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 32'($urandom_range(0, 40));
                default: ;
            endcase
            do_op(op, a, b, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        // Reset mid-multiply: nothing may surface afterwards.
        idle(1);
        ScrA       = 32'd1234;
        ScrB       = 32'd5678;
        ALUControl = 3'd6;
        FlagEn     = 1'b1;
        InValid    = 1'b1;
        tick();
        InValid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mul_pre_rst_busy", Busy, 1'b1);
        RESETn = 1'b0;
        tick();
        RESETn  = 1'b1;
        m_res   = '0;
        m_flags = '0;
        m_valid = 1'b0;
        chk("mrst_busy", Busy, 1'b0);
        chk("mrst_in_ready", InReady, 1'b1);
        check_out("mrst");
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (OutValid || Busy) stale = 1'b1;
        end
        chk("mrst_no_stale", stale, 1'b0);

        // Reset wins over a same-cycle accept.
        ScrA       = 32'd1;
        ScrB       = 32'd2;
        ALUControl = 3'd0;
        FlagEn     = 1'b1;
        InValid    = 1'b1;
        RESETn     = 1'b0;
        tick();
        InValid = 1'b0;
        RESETn  = 1'b1;
        check_out("rst_vs_accept");

        do_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
        do_op(3'd3, 32'h0, 32'h0, 1'b1);
        do_op(3'd4, 32'h0, 32'h8000_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
